// File: rtl/issue_if.sv
// Fetch/issue bundle between the issue controller and its neighbours
// (instruction memory, hazard detector, decode, execute).
//
// Signals:
//   stall_in        hazard detector stall, stable at posedge
//   redirect_valid  taken branch/jump resolved in EX this cycle
//   redirect_pc     redirect target PC
//   imem_data       instruction word at imem_addr (combinational read)
//   imem_addr       current PC
//   dec_instr       IF/ID instruction (to decode and hazard detector)
//   dec_pc          PC of dec_instr
//   ex_instr        ID/EX instruction to execute
//   ex_pc           PC of ex_instr
//   bubble_out      ex_instr is an inserted bubble
//   bubble_cnt      saturating count of inserted bubbles
//   stall_err       sticky stall-watchdog error
//
// Modports: master = issue controller, slave = surrounding pipeline.
interface issue_if;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic        bubble_out;
  logic [15:0] bubble_cnt;
  logic        stall_err;

  modport master (
    input  stall_in, redirect_valid, redirect_pc, imem_data,
    output imem_addr, dec_instr, dec_pc, ex_instr, ex_pc, bubble_out, bubble_cnt, stall_err
  );

  modport slave (
    output stall_in, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, dec_instr, dec_pc, ex_instr, ex_pc, bubble_out, bubble_cnt, stall_err
  );
endinterface

// File: rtl/issue_controller.sv
// Fetch/issue control stage of the 5-stage MIPS pipeline. Owns the PC, the
// IF/ID and the ID/EX instruction registers. A stall freezes PC and decode and
// drops a NOP into execute; a redirect from EX reloads the PC and flushes both
// decode and execute for one cycle.
//
// Ports:
//   clk    pipeline clock, all state updates on posedge
//   reset  synchronous, active-high
//   bus    issue_if.master (see rtl/issue_if.sv for signal list)
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   NOP        encoding used for bubbles and flushes
//   MAX_STALL  consecutive-stall watchdog threshold (only with the macro)
//
// Optional feature: define ISSUE_STALL_WATCHDOG_EN to add an 8-bit
// consecutive-stall counter that sets sticky stall_err on reaching MAX_STALL.
// Without it stall_err is tied low.
module issue_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
`ifdef ISSUE_STALL_WATCHDOG_EN
  ,
  parameter int unsigned MAX_STALL = 8
`endif
) (
  input logic     clk,
  input logic     reset,
  issue_if.master bus
);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dec_instr_q, dec_instr_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic [31:0] ex_instr_q, ex_instr_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      dec_instr_q  <= NOP;
      dec_pc_q     <= RESET_PC;
      ex_instr_q   <= NOP;
      ex_pc_q      <= RESET_PC;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dec_instr_q  <= dec_instr_d;
      dec_pc_q     <= dec_pc_d;
      ex_instr_q   <= ex_instr_d;
      ex_pc_q      <= ex_pc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Priority: redirect > stall > normal flow. FLUSH needs no state-specific
  // handling; it only lasts the one cycle its bubble is visible.
  always_comb begin
    state_d     = StRun;
    pc_d        = pc_q + 32'd4;
    dec_instr_d = bus.imem_data;
    dec_pc_d    = pc_q;
    ex_instr_d  = dec_instr_q;
    ex_pc_d     = dec_pc_q;

    if (bus.redirect_valid) begin
      state_d     = StFlush;
      pc_d        = bus.redirect_pc;
      dec_instr_d = NOP;
      ex_instr_d  = NOP;
    end else if (bus.stall_in) begin
      // Hold decode so the hazard detector re-evaluates the same instruction.
      state_d     = StStall;
      pc_d        = pc_q;
      dec_instr_d = dec_instr_q;
      dec_pc_d    = dec_pc_q;
      ex_instr_d  = NOP;
    end

    bubble_cnt_d = bubble_cnt_q;
    if (state_d != StRun && bubble_cnt_q != 16'hFFFF) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.dec_instr  = dec_instr_q;
  assign bus.dec_pc     = dec_pc_q;
  assign bus.ex_instr   = ex_instr_q;
  assign bus.ex_pc      = ex_pc_q;
  // Every non-RUN state is entered exactly on a cycle that inserted a bubble.
  assign bus.bubble_out = (state_q != StRun);
  assign bus.bubble_cnt = bubble_cnt_q;

`ifdef ISSUE_STALL_WATCHDOG_EN
  logic [7:0] stall_run_q, stall_run_d;
  logic       stall_err_q, stall_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_run_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_run_q <= stall_run_d;
      stall_err_q <= stall_err_d;
    end
  end

  always_comb begin
    stall_run_d = '0;
    stall_err_d = stall_err_q;
    if (state_d == StStall) begin
      stall_run_d = (stall_run_q == 8'hFF) ? stall_run_q : stall_run_q + 8'd1;
      if (32'(stall_run_d) >= MAX_STALL) begin
        stall_err_d = 1'b1;
      end
    end
  end

  assign bus.stall_err = stall_err_q;
`else
  assign bus.stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_issue_controller.sv
module tb_issue_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_if bus ();

  issue_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory, word-indexed by PC[9:2].
  logic [31:0] imem [256];
  assign bus.imem_data = imem[bus.imem_addr[9:2]];

`ifdef ISSUE_STALL_WATCHDOG_EN
  localparam bit WdOn = 1'b1;
`else
  localparam bit WdOn = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: pipeline contents as the spec describes them.
  logic [31:0] m_pc, m_dec, m_dpc, m_ex, m_epc;
  bit          m_bub, m_err;
  int          m_cnt, m_run;
  bit          m_dpc_known, m_epc_known;  // PCs carried by flushed slots are unspecified

  task automatic model_step(input bit rst, input bit stall, input bit redir,
                            input logic [31:0] rpc);
    logic [31:0] fetched;
    fetched = imem[m_pc[9:2]];
    if (rst) begin
      m_pc = 32'h0; m_dec = 32'h0; m_ex = 32'h0; m_dpc = 32'h0; m_epc = 32'h0;
      m_bub = 0; m_cnt = 0; m_err = 0; m_run = 0;
      m_dpc_known = 1; m_epc_known = 1;
      return;
    end
    if (redir) begin
      m_pc = rpc; m_dec = 32'h0; m_ex = 32'h0; m_bub = 1;
      m_dpc_known = 0; m_epc_known = 0;
      m_run = 0;
    end else if (stall) begin
      m_ex = 32'h0; m_epc = m_dpc; m_epc_known = m_dpc_known; m_bub = 1;
      m_run++;
      if (WdOn && m_run >= 8) m_err = 1;
    end else begin
      m_ex = m_dec; m_epc = m_dpc; m_epc_known = m_dpc_known;
      m_dec = fetched; m_dpc = m_pc; m_dpc_known = 1;
      m_pc = m_pc + 32'd4; m_bub = 0;
      m_run = 0;
    end
    if (m_bub && m_cnt < 65535) m_cnt++;
  endtask

  task automatic cycle(input bit rst, input bit stall, input bit redir,
                       input logic [31:0] rpc);
    reset = rst;
    bus.stall_in = stall;
    bus.redirect_valid = redir;
    bus.redirect_pc = rpc;
    model_step(rst, stall, redir, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 32'h100);
    checks++; if (bus.imem_addr !== 32'h0)
      begin errors++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    checks++; if (bus.dec_instr !== 32'h0)
      begin errors++; $display("FAIL reset_dec: got %h want 0", bus.dec_instr); end
    checks++; if (bus.ex_instr !== 32'h0)
      begin errors++; $display("FAIL reset_ex: got %h want 0", bus.ex_instr); end
    checks++; if (bus.bubble_cnt !== 16'h0 || bus.bubble_out !== 1'b0 || bus.stall_err !== 1'b0)
      begin errors++; $display("FAIL reset_flags: got cnt=%h bub=%b err=%b want 0/0/0",
                               bus.bubble_cnt, bus.bubble_out, bus.stall_err); end
  endtask

  task automatic test_straight_line;
    logic [31:0] want_dec [3];
    logic [31:0] want_ex [3];
    want_dec = '{32'h20080001, 32'h20090002, 32'h200A0003};
    want_ex  = '{32'h0, 32'h20080001, 32'h20090002};
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      checks++; if (bus.imem_addr !== 32'(4 * (i + 1)))
        begin errors++; $display("FAIL straight_addr[%0d]: got %h want %h", i, bus.imem_addr,
                                 32'(4 * (i + 1))); end
      checks++; if (bus.dec_instr !== want_dec[i] || bus.ex_instr !== want_ex[i])
        begin errors++; $display("FAIL straight_pipe[%0d]: got dec=%h ex=%h want %h %h", i,
                                 bus.dec_instr, bus.ex_instr, want_dec[i], want_ex[i]); end
      checks++; if (bus.bubble_out !== 1'b0 || bus.bubble_cnt !== 16'h0)
        begin errors++; $display("FAIL straight_bubble[%0d]: got bub=%b cnt=%0d want 0 0", i,
                                 bus.bubble_out, bus.bubble_cnt); end
    end
  endtask

  task automatic test_single_stall;
    cycle(0, 0, 0, 0);  // fetch 0x01095020 from address 12
    checks++; if (bus.dec_instr !== 32'h01095020 || bus.dec_pc !== 32'hC)
      begin errors++; $display("FAIL stall_setup: got dec=%h pc=%h want 01095020 c",
                               bus.dec_instr, bus.dec_pc); end
    cycle(0, 1, 0, 0);
    checks++; if (bus.imem_addr !== 32'h10 || bus.dec_instr !== 32'h01095020)
      begin errors++; $display("FAIL stall_hold: got addr=%h dec=%h want 10 01095020",
                               bus.imem_addr, bus.dec_instr); end
    checks++; if (bus.ex_instr !== 32'h0 || bus.bubble_out !== 1'b1 || bus.bubble_cnt !== 16'd1)
      begin errors++; $display("FAIL stall_bubble: got ex=%h bub=%b cnt=%0d want 0 1 1",
                               bus.ex_instr, bus.bubble_out, bus.bubble_cnt); end
    cycle(0, 0, 0, 0);
    checks++; if (bus.ex_instr !== 32'h01095020 || bus.ex_pc !== 32'hC ||
                  bus.imem_addr !== 32'h14 || bus.bubble_out !== 1'b0)
      begin errors++; $display("FAIL stall_resume: got ex=%h expc=%h addr=%h bub=%b want 01095020 c 14 0",
                               bus.ex_instr, bus.ex_pc, bus.imem_addr, bus.bubble_out); end
  endtask

  task automatic test_redirect;
    cycle(0, 1, 1, 32'h40);
    checks++; if (bus.imem_addr !== 32'h40 || bus.dec_instr !== 32'h0 || bus.ex_instr !== 32'h0)
      begin errors++; $display("FAIL redirect_flush: got addr=%h dec=%h ex=%h want 40 0 0",
                               bus.imem_addr, bus.dec_instr, bus.ex_instr); end
    checks++; if (bus.bubble_out !== 1'b1 || bus.bubble_cnt !== 16'd2)
      begin errors++; $display("FAIL redirect_bubble: got bub=%b cnt=%0d want 1 2",
                               bus.bubble_out, bus.bubble_cnt); end
    cycle(0, 0, 0, 0);
    checks++; if (bus.dec_pc !== 32'h40 || bus.dec_instr !== imem[16] ||
                  bus.imem_addr !== 32'h44 || bus.bubble_out !== 1'b0)
      begin errors++; $display("FAIL redirect_resume: got dpc=%h dec=%h addr=%h bub=%b want 40 %h 44 0",
                               bus.dec_pc, bus.dec_instr, bus.imem_addr, bus.bubble_out, imem[16]); end
  endtask

  task automatic test_wrap;
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    checks++; if (bus.imem_addr !== 32'h0 || bus.dec_pc !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL pc_wrap: got addr=%h dpc=%h want 0 fffffffc",
                               bus.imem_addr, bus.dec_pc); end
  endtask

  task automatic test_reset_mid_stall;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    checks++; if (bus.imem_addr !== 32'h0 || bus.dec_instr !== 32'h0 || bus.ex_instr !== 32'h0 ||
                  bus.bubble_out !== 1'b0 || bus.bubble_cnt !== 16'h0)
      begin errors++; $display("FAIL reset_mid_stall: got addr=%h dec=%h ex=%h bub=%b cnt=%0d want all 0",
                               bus.imem_addr, bus.dec_instr, bus.ex_instr, bus.bubble_out,
                               bus.bubble_cnt); end
    cycle(0, 0, 0, 0);
    checks++; if (bus.imem_addr !== 32'h4 || bus.bubble_out !== 1'b0)
      begin errors++; $display("FAIL reset_mid_stall_run: got addr=%h bub=%b want 4 0",
                               bus.imem_addr, bus.bubble_out); end
  endtask

  task automatic test_watchdog;
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, 0, 0);
      if (i == 7) begin
        checks++; if (bus.stall_err !== 1'b0)
          begin errors++; $display("FAIL wd_early: got %b want 0", bus.stall_err); end
      end
    end
    checks++; if (bus.stall_err !== WdOn)
      begin errors++; $display("FAIL wd_trip: got %b want %b", bus.stall_err, WdOn); end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    checks++; if (bus.stall_err !== WdOn)
      begin errors++; $display("FAIL wd_sticky: got %b want %b", bus.stall_err, WdOn); end
    cycle(1, 0, 0, 0);
    checks++; if (bus.stall_err !== 1'b0)
      begin errors++; $display("FAIL wd_reset: got %b want 0", bus.stall_err); end
  endtask

  task automatic test_random;
    bit st, rd, rs;
    logic [31:0] rpc;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rs  = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 35);
      rd  = ($urandom_range(0, 99) < 10);
      rpc = $urandom & 32'hFFFF_FFFC;
      cycle(rs, st, rd, rpc);
      checks++; if (bus.imem_addr !== m_pc || bus.dec_instr !== m_dec || bus.ex_instr !== m_ex)
        begin errors++; $display("FAIL rand_pipe[%0d]: got %h/%h/%h want %h/%h/%h", i,
                                 bus.imem_addr, bus.dec_instr, bus.ex_instr, m_pc, m_dec, m_ex); end
      checks++; if (bus.bubble_out !== m_bub || bus.bubble_cnt !== 16'(m_cnt) ||
                    bus.stall_err !== m_err)
        begin errors++; $display("FAIL rand_flags[%0d]: got bub=%b cnt=%0d err=%b want %b %0d %b", i,
                                 bus.bubble_out, bus.bubble_cnt, bus.stall_err, m_bub, m_cnt,
                                 m_err); end
      if (m_dpc_known) begin
        checks++; if (bus.dec_pc !== m_dpc)
          begin errors++; $display("FAIL rand_dpc[%0d]: got %h want %h", i, bus.dec_pc, m_dpc); end
      end
      if (m_epc_known) begin
        checks++; if (bus.ex_pc !== m_epc)
          begin errors++; $display("FAIL rand_epc[%0d]: got %h want %h", i, bus.ex_pc, m_epc); end
      end
    end
  endtask

  task automatic test_saturation;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 65535; i++) cycle(0, 1, 0, 0);
    checks++; if (bus.bubble_cnt !== 16'hFFFF)
      begin errors++; $display("FAIL sat_reach: got %h want ffff", bus.bubble_cnt); end
    cycle(0, 0, 1, 32'h80);
    checks++; if (bus.bubble_cnt !== 16'hFFFF || bus.imem_addr !== 32'h80)
      begin errors++; $display("FAIL sat_hold: got cnt=%h addr=%h want ffff 80",
                               bus.bubble_cnt, bus.imem_addr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h20080001;
    imem[1] = 32'h20090002;
    imem[2] = 32'h200A0003;
    imem[3] = 32'h01095020;
    reset = 1'b1;
    bus.stall_in = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    #1;
    test_reset();
    test_straight_line();
    test_single_stall();
    test_redirect();
    test_wrap();
    test_reset_mid_stall();
    test_watchdog();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
